// File: rtl/lsb_queue.sv
// In-order load/store buffer between dispatch/ROB and the memory port.
// Snoops ALU and load broadcasts; stores issue only once committed.
module lsb_queue #(
   parameter int LSB_SIZE = 16,
   parameter int LSB_W    = 4,
   parameter int ROB_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             clr,
   input  logic             disp_s,
   input  logic [3:0]       disp_op,
   input  logic [31:0]      disp_imm,
   input  logic [ROB_W-1:0] disp_reorder,
   input  logic             disp_rs1_ready,
   input  logic [31:0]      disp_rs1_value,
   input  logic [ROB_W-1:0] disp_rs1_tag,
   input  logic             disp_rs2_ready,
   input  logic [31:0]      disp_rs2_value,
   input  logic [ROB_W-1:0] disp_rs2_tag,
   input  logic             alu_s,
   input  logic [ROB_W-1:0] alu_reorder,
   input  logic [31:0]      alu_value,
   input  logic             commit_s,
   input  logic [ROB_W-1:0] commit_reorder,
   output logic             lsb_full,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [1:0]       mem_len,
   input  logic             mem_done,
   input  logic [31:0]      mem_rdata,
   output logic             load_s,
   output logic [ROB_W-1:0] load_reorder,
   output logic [31:0]      load_value
);

   // op encoding: [3]=store, [2]=unsigned, [1:0]=size
   localparam int CW = LSB_W + 1;

   typedef struct packed {
      logic             valid;
      logic             cmt;
      logic [3:0]       op;
      logic [31:0]      imm;
      logic [ROB_W-1:0] tag;
      logic             r1_rdy;
      logic [31:0]      r1_val;
      logic [ROB_W-1:0] r1_tag;
      logic             r2_rdy;
      logic [31:0]      r2_val;
      logic [ROB_W-1:0] r2_tag;
   } ent_t;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   ent_t             ent_q [LSB_SIZE];
   ent_t             ent_d [LSB_SIZE];
   logic [LSB_W-1:0] head_q, head_d;
   logic [LSB_W-1:0] tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    ccnt_q, ccnt_d;
   state_t           state_q, state_d;
   logic             full_q, full_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [1:0]       mem_len_q, mem_len_d;
   logic             load_s_q, load_s_d;
   logic [ROB_W-1:0] load_reorder_q, load_reorder_d;
   logic [31:0]      load_value_q, load_value_d;

   logic [LSB_W-1:0] cmt_idx;
   ent_t             head_ent;
   ent_t             new_ent;
   logic             ins, ret, ret_st, cmt;

   function automatic logic [31:0] ext(input logic [3:0] op,
                                       input logic [31:0] d);
      logic [31:0] r;
      case (op[1:0])
         2'd0:    r = op[2] ? {24'b0, d[7:0]} : {{24{d[7]}}, d[7:0]};
         2'd1:    r = op[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   assign cmt_idx  = head_q + ccnt_q[LSB_W-1:0];
   assign head_ent = ent_q[head_q];

   always_comb begin
      new_ent        = '0;
      new_ent.valid  = 1'b1;
      new_ent.op     = disp_op;
      new_ent.imm    = disp_imm;
      new_ent.tag    = disp_reorder;
      new_ent.r1_rdy = disp_rs1_ready;
      new_ent.r1_val = disp_rs1_value;
      new_ent.r1_tag = disp_rs1_tag;
      new_ent.r2_rdy = disp_rs2_ready;
      new_ent.r2_val = disp_rs2_value;
      new_ent.r2_tag = disp_rs2_tag;
      // operands produced in the insert cycle must not be missed
      if (!disp_rs1_ready) begin
         if (alu_s && disp_rs1_tag == alu_reorder) begin
            new_ent.r1_rdy = 1'b1;
            new_ent.r1_val = alu_value;
         end else if (load_s_q && disp_rs1_tag == load_reorder_q) begin
            new_ent.r1_rdy = 1'b1;
            new_ent.r1_val = load_value_q;
         end
      end
      if (!disp_rs2_ready) begin
         if (alu_s && disp_rs2_tag == alu_reorder) begin
            new_ent.r2_rdy = 1'b1;
            new_ent.r2_val = alu_value;
         end else if (load_s_q && disp_rs2_tag == load_reorder_q) begin
            new_ent.r2_rdy = 1'b1;
            new_ent.r2_val = load_value_q;
         end
      end
   end

   always_comb begin
      ent_d          = ent_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      ccnt_d         = ccnt_q;
      state_d        = state_q;
      full_d         = full_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      mem_len_d      = mem_len_q;
      load_s_d       = 1'b0;
      load_reorder_d = load_reorder_q;
      load_value_d   = load_value_q;
      ins            = 1'b0;
      ret            = 1'b0;
      ret_st         = 1'b0;
      cmt            = 1'b0;
      if (rdy) begin
         for (int i = 0; i < LSB_SIZE; i++) begin
            if (ent_q[i].valid && !ent_q[i].r1_rdy) begin
               if (alu_s && ent_q[i].r1_tag == alu_reorder) begin
                  ent_d[i].r1_rdy = 1'b1;
                  ent_d[i].r1_val = alu_value;
               end else if (load_s_q && ent_q[i].r1_tag == load_reorder_q) begin
                  ent_d[i].r1_rdy = 1'b1;
                  ent_d[i].r1_val = load_value_q;
               end
            end
            if (ent_q[i].valid && !ent_q[i].r2_rdy) begin
               if (alu_s && ent_q[i].r2_tag == alu_reorder) begin
                  ent_d[i].r2_rdy = 1'b1;
                  ent_d[i].r2_val = alu_value;
               end else if (load_s_q && ent_q[i].r2_tag == load_reorder_q) begin
                  ent_d[i].r2_rdy = 1'b1;
                  ent_d[i].r2_val = load_value_q;
               end
            end
         end
         if (commit_s && !clr) begin
            cmt                 = 1'b1;
            ent_d[cmt_idx].cmt = 1'b1;
         end
         unique case (state_q)
            S_IDLE: begin
               if (!clr && head_ent.valid && head_ent.r1_rdy &&
                   (!head_ent.op[3] || (head_ent.r2_rdy && head_ent.cmt))) begin
                  state_d     = S_BUSY;
                  mem_req_d   = 1'b1;
                  mem_we_d    = head_ent.op[3];
                  mem_addr_d  = head_ent.r1_val + head_ent.imm;
                  mem_wdata_d = head_ent.r2_val;
                  mem_len_d   = head_ent.op[1:0];
               end
            end
            S_BUSY: begin
               // a flushed load is dropped; committed stores must finish
               if (clr && !mem_we_q) begin
                  state_d   = S_IDLE;
                  mem_req_d = 1'b0;
               end else if (mem_done) begin
                  state_d   = S_IDLE;
                  mem_req_d = 1'b0;
                  ret       = 1'b1;
                  ret_st    = head_ent.op[3];
                  if (!head_ent.op[3]) begin
                     load_s_d       = !clr;
                     load_reorder_d = head_ent.tag;
                     load_value_d   = ext(head_ent.op, mem_rdata);
                  end
               end
            end
         endcase
         if (ret) begin
            ent_d[head_q].valid = 1'b0;
            ent_d[head_q].cmt   = 1'b0;
            head_d              = head_q + 1'b1;
         end
         if (clr) begin
            for (int i = 0; i < LSB_SIZE; i++) begin
               if (!ent_d[i].cmt) ent_d[i].valid = 1'b0;
            end
         end else if (disp_s) begin
            ins           = 1'b1;
            ent_d[tail_q] = new_ent;
            tail_d        = tail_q + 1'b1;
         end
         count_d = count_q + CW'(ins) - CW'(ret);
         ccnt_d  = ccnt_q + CW'(cmt) - CW'(ret_st);
         if (clr) begin
            tail_d  = head_d + ccnt_d[LSB_W-1:0];
            count_d = ccnt_d;
         end
         full_d = (count_d >= CW'(LSB_SIZE - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LSB_SIZE; i++) ent_q[i] <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         ccnt_q         <= '0;
         state_q        <= S_IDLE;
         full_q         <= 1'b0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         mem_len_q      <= '0;
         load_s_q       <= 1'b0;
         load_reorder_q <= '0;
         load_value_q   <= '0;
      end else begin
         if (rdy && commit_s && !clr)
            assert (ent_q[cmt_idx].valid && ent_q[cmt_idx].op[3] &&
                    ent_q[cmt_idx].tag == commit_reorder);
         ent_q          <= ent_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         ccnt_q         <= ccnt_d;
         state_q        <= state_d;
         full_q         <= full_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         mem_len_q      <= mem_len_d;
         load_s_q       <= load_s_d;
         load_reorder_q <= load_reorder_d;
         load_value_q   <= load_value_d;
      end
   end

   assign lsb_full     = full_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_len      = mem_len_q;
   assign load_s       = load_s_q;
   assign load_reorder = load_reorder_q;
   assign load_value   = load_value_q;

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: load vector table plus store, flush,
// full/wrap and same-cycle snoop sequences.
module tb_lsb_queue;

   localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2;
   localparam logic [3:0] LBU = 4'h4, LHU = 4'h5, SW = 4'hA;

   logic        clk = 1'b0;
   logic        rst, rdy, clr;
   logic        disp_s;
   logic [3:0]  disp_op;
   logic [31:0] disp_imm;
   logic [3:0]  disp_reorder;
   logic        disp_rs1_ready, disp_rs2_ready;
   logic [31:0] disp_rs1_value, disp_rs2_value;
   logic [3:0]  disp_rs1_tag, disp_rs2_tag;
   logic        alu_s;
   logic [3:0]  alu_reorder;
   logic [31:0] alu_value;
   logic        commit_s;
   logic [3:0]  commit_reorder;
   logic        lsb_full, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [1:0]  mem_len;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        load_s;
   logic [3:0]  load_reorder;
   logic [31:0] load_value;

   int nchk = 0;
   int npass = 0;

   always #5 clk = ~clk;

   lsb_queue dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
      .disp_s(disp_s), .disp_op(disp_op), .disp_imm(disp_imm),
      .disp_reorder(disp_reorder),
      .disp_rs1_ready(disp_rs1_ready), .disp_rs1_value(disp_rs1_value),
      .disp_rs1_tag(disp_rs1_tag),
      .disp_rs2_ready(disp_rs2_ready), .disp_rs2_value(disp_rs2_value),
      .disp_rs2_tag(disp_rs2_tag),
      .alu_s(alu_s), .alu_reorder(alu_reorder), .alu_value(alu_value),
      .commit_s(commit_s), .commit_reorder(commit_reorder),
      .lsb_full(lsb_full), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .load_s(load_s), .load_reorder(load_reorder), .load_value(load_value)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs1;
      logic [31:0] imm;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] val;
   } vec_t;

   vec_t vecs [7];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic disp(input logic [3:0] op, input logic [31:0] imm,
                       input logic [3:0] tag,
                       input logic r1r, input logic [31:0] r1v,
                       input logic [3:0] r1t,
                       input logic r2r, input logic [31:0] r2v,
                       input logic [3:0] r2t);
      disp_s = 1'b1; disp_op = op; disp_imm = imm; disp_reorder = tag;
      disp_rs1_ready = r1r; disp_rs1_value = r1v; disp_rs1_tag = r1t;
      disp_rs2_ready = r2r; disp_rs2_value = r2v; disp_rs2_tag = r2t;
      tick;
      disp_s = 1'b0;
   endtask

   task automatic wait_req(input string nm);
      int n = 0;
      while (!mem_req && n < 50) begin
         tick;
         n++;
      end
      chk({nm, " req"}, 32'(mem_req), 32'd1);
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; clr = 1'b0; disp_s = 1'b0;
      disp_op = '0; disp_imm = '0; disp_reorder = '0;
      disp_rs1_ready = 1'b0; disp_rs1_value = '0; disp_rs1_tag = '0;
      disp_rs2_ready = 1'b0; disp_rs2_value = '0; disp_rs2_tag = '0;
      alu_s = 1'b0; alu_reorder = '0; alu_value = '0;
      commit_s = 1'b0; commit_reorder = '0;
      mem_done = 1'b0; mem_rdata = '0;

      vecs[0] = '{LW,  32'h1000, 32'h8, 32'hDEADBEEF, 32'h1008, 2'd2, 32'hDEADBEEF};
      vecs[1] = '{LB,  32'h2000, 32'hFFFFFFFF, 32'h80, 32'h1FFF, 2'd0, 32'hFFFFFF80};
      vecs[2] = '{LBU, 32'h2000, 32'hFFFFFFFF, 32'h80, 32'h1FFF, 2'd0, 32'h00000080};
      vecs[3] = '{LH,  32'h3000, 32'h2, 32'h00008001, 32'h3002, 2'd1, 32'hFFFF8001};
      vecs[4] = '{LHU, 32'h3000, 32'h2, 32'h00008001, 32'h3002, 2'd1, 32'h00008001};
      vecs[5] = '{LW,  32'hFFFFFFFC, 32'h8, 32'h12345678, 32'h4, 2'd2, 32'h12345678};
      vecs[6] = '{LB,  32'h10, 32'h0, 32'h0000A57F, 32'h10, 2'd0, 32'h0000007F};

      tick; tick;
      rst = 1'b0;
      chk("rst mem_req", 32'(mem_req), 0);
      chk("rst load_s", 32'(load_s), 0);
      chk("rst full", 32'(lsb_full), 0);
      chk("rst addr", mem_addr, 0);

      for (int i = 0; i < 7; i++) begin
         disp(vecs[i].op, vecs[i].imm, 4'(i + 3), 1'b1, vecs[i].rs1, 4'd0,
              1'b1, 32'd0, 4'd0);
         wait_req("vec");
         chk("vec addr", mem_addr, vecs[i].addr);
         chk("vec len", 32'(mem_len), 32'(vecs[i].len));
         chk("vec we", 32'(mem_we), 0);
         mem_done = 1'b1; mem_rdata = vecs[i].rdata;
         tick;
         mem_done = 1'b0;
         chk("vec load_s", 32'(load_s), 1);
         chk("vec tag", 32'(load_reorder), 32'(i + 3));
         chk("vec value", load_value, vecs[i].val);
         chk("vec req drop", 32'(mem_req), 0);
         tick;
         chk("vec load_s pulse", 32'(load_s), 0);
      end

      // store waits on ALU data then on commit
      disp(SW, 32'h4, 4'd4, 1'b1, 32'h100, 4'd0, 1'b0, 32'd0, 4'd5);
      alu_s = 1'b1; alu_reorder = 4'd5; alu_value = 32'h55;
      tick;
      alu_s = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      chk("st no req before commit", 32'(mem_req), 0);
      commit_s = 1'b1; commit_reorder = 4'd4;
      tick;
      commit_s = 1'b0;
      wait_req("st");
      chk("st we", 32'(mem_we), 1);
      chk("st wdata", mem_wdata, 32'h55);
      chk("st addr", mem_addr, 32'h104);
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
      chk("st no load_s", 32'(load_s), 0);
      chk("st req drop", 32'(mem_req), 0);

      // flush while a committed store is in flight
      disp(SW, 32'h0, 4'd1, 1'b1, 32'h400, 4'd0, 1'b1, 32'hCAFE, 4'd0);
      commit_s = 1'b1; commit_reorder = 4'd1;
      disp(LW, 32'h0, 4'd2, 1'b1, 32'h500, 4'd0, 1'b0, 32'd0, 4'd0);
      commit_s = 1'b0;
      disp(LH, 32'h0, 4'd3, 1'b1, 32'h600, 4'd0, 1'b0, 32'd0, 4'd0);
      wait_req("clr st");
      chk("clr st addr", mem_addr, 32'h400);
      clr = 1'b1;
      tick;
      clr = 1'b0;
      chk("clr st req held", 32'(mem_req), 1);
      chk("clr st we", 32'(mem_we), 1);
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("clr loads gone", 32'({mem_req, load_s}), 0);
         tick;
      end

      // fill to full, retire+insert at full, drain across the wrap
      disp(LW, 32'h0, 4'd0, 1'b1, 32'h8000, 4'd0, 1'b0, 32'd0, 4'd0);
      for (int i = 1; i < 15; i++) begin
         if (i == 14) chk("fill not full at 14", 32'(lsb_full), 0);
         disp(LW, 32'(i * 4), 4'(i), 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd0);
      end
      chk("full at 15", 32'(lsb_full), 1);
      chk("fill head req", 32'(mem_req), 1);
      mem_done = 1'b1; mem_rdata = 32'h0;
      disp(LW, 32'(15 * 4), 4'd15, 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd0);
      mem_done = 1'b0;
      chk("fill retire load_s", 32'(load_s), 1);
      chk("fill retire tag", 32'(load_reorder), 0);
      chk("full after ins+ret", 32'(lsb_full), 1);
      alu_s = 1'b1; alu_reorder = 4'd15; alu_value = 32'h8000;
      tick;
      alu_s = 1'b0;
      for (int i = 1; i < 16; i++) begin
         wait_req("drain");
         chk("drain addr", mem_addr, 32'h8000 + 32'(i * 4));
         mem_done = 1'b1; mem_rdata = 32'(i);
         tick;
         mem_done = 1'b0;
         chk("drain tag", 32'(load_reorder), 32'(i));
         chk("drain value", load_value, 32'(i));
         if (i == 1) chk("full drop", 32'(lsb_full), 0);
      end

      // base operand produced in the same cycle as insert
      alu_s = 1'b1; alu_reorder = 4'd7; alu_value = 32'h2000;
      disp(LW, 32'h10, 4'd6, 1'b0, 32'd0, 4'd7, 1'b0, 32'd0, 4'd0);
      alu_s = 1'b0;
      wait_req("snoop");
      chk("snoop addr", mem_addr, 32'h2010);
      mem_done = 1'b1; mem_rdata = 32'h77;
      tick;
      mem_done = 1'b0;
      chk("snoop tag", 32'(load_reorder), 6);
      chk("snoop value", load_value, 32'h77);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
